// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to an incoming LFSR word stream and flags mismatches.
// Optional word counter enabled by defining LFSR_CHK_WORDCNT_EN.
module lfsr_checker #(
  parameter int unsigned      NBITS    = 16,
  parameter logic [NBITS-1:0] TAPS     = 16'hB400,
  parameter int unsigned      LOCK_CNT = 4,
  parameter int unsigned      LOSS_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [NBITS-1:0] q_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_cnt,
  output logic [NBITS-1:0] expected,
  output logic [31:0]      word_cnt
);

  localparam logic [3:0] LockCntW = LOCK_CNT[3:0];
  localparam logic [3:0] LossCntW = LOSS_CNT[3:0];

  typedef enum logic {StSearch, StLocked} state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] pred_q, pred_d;
  logic [3:0]       run_q, run_d;
  logic             err_pulse_q, err_pulse_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic             match, nonzero, count_err;
  logic [3:0]       run_inc;

  function automatic logic [NBITS-1:0] step(input logic [NBITS-1:0] s);
    return {s[NBITS-2:0], ^(s & TAPS)};
  endfunction

  assign match   = (q_in == pred_q);
  assign nonzero = |q_in;
  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    run_d       = run_q;
    err_pulse_d = 1'b0;
    count_err   = 1'b0;

    if (valid) begin
      unique case (state_q)
        StSearch: begin
          if (match && nonzero) begin
            pred_d = step(pred_q);
            if (run_inc == LockCntW) begin
              state_d = StLocked;
              run_d   = 4'd0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            // An all-zero word is the LFSR lock-up state and must never seed.
            run_d = 4'd0;
            if (nonzero) pred_d = step(q_in);
          end
        end
        StLocked: begin
          // Free-run the prediction so isolated bit errors cannot desynchronise us.
          pred_d = step(pred_q);
          if (match) begin
            run_d = 4'd0;
          end else begin
            err_pulse_d = 1'b1;
            count_err   = 1'b1;
            if (run_inc == LossCntW) begin
              state_d = StSearch;
              run_d   = 4'd0;
              pred_d  = nonzero ? step(q_in) : pred_q;
            end else begin
              run_d = run_inc;
            end
          end
        end
        default: ;
      endcase
    end

    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = count_err ? 16'd1 : 16'd0;
    end else if (count_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StSearch;
      pred_q      <= '0;
      run_q       <= 4'd0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      run_q       <= run_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign expected  = pred_q;

`ifdef LFSR_CHK_WORDCNT_EN
  logic [31:0] word_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= 32'd0;
    end else if (valid && (state_q == StLocked)) begin
      word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

  assign word_cnt = word_cnt_q;
`else
  assign word_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: scoreboarded main stream plus a second instance
// (LOSS_CNT=15) used to drive the error counter into saturation.
module tb_lfsr_checker;

  localparam logic [15:0] Taps  = 16'hB400;
  localparam int          LockN = 4;
  localparam int          LossN = 4;
`ifdef LFSR_CHK_WORDCNT_EN
  localparam bit WcEn = 1'b1;
`else
  localparam bit WcEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, clr_cnt, locked, err_pulse;
  logic [15:0] q_in, err_cnt, expected;
  logic [31:0] word_cnt;

  logic        s_rst, s_valid, s_clr, s_locked, s_err_pulse;
  logic [15:0] s_q, s_err_cnt, s_expected;
  logic [31:0] s_word_cnt;

  lfsr_checker u_dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .q_in     (q_in),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt),
    .expected (expected),
    .word_cnt (word_cnt)
  );

  lfsr_checker #(.LOSS_CNT(15)) u_sat (
    .clk      (clk),
    .rst      (s_rst),
    .valid    (s_valid),
    .q_in     (s_q),
    .clr_cnt  (s_clr),
    .locked   (s_locked),
    .err_pulse(s_err_pulse),
    .err_cnt  (s_err_cnt),
    .expected (s_expected),
    .word_cnt (s_word_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] s);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (Taps[i]) fb = fb ^ s[i];
    end
    return {s[14:0], fb};
  endfunction

  typedef struct {
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic [15:0] ex;
    logic [31:0] wc;
  } exp_t;

  exp_t sb[$];

  bit          m_lk;
  logic [15:0] m_pred;
  int          m_run;
  int          m_ec;
  logic [31:0] m_wc;

  // Drive one cycle on the main instance, push the model's prediction, compare after the edge.
  task automatic drive(input logic v, input logic [15:0] d, input logic c, input logic r);
    exp_t        e;
    logic [15:0] old;
    bit          cerr;
    valid   = v;
    q_in    = d;
    clr_cnt = c;
    rst     = r;
    cerr    = 1'b0;
    if (r) begin
      m_lk = 1'b0; m_pred = '0; m_run = 0; m_ec = 0; m_wc = '0;
    end else begin
      if (v) begin
        if (!m_lk) begin
          if (d == m_pred && d != 16'h0) begin
            m_run++;
            m_pred = nxt(m_pred);
            if (m_run == LockN) begin
              m_lk = 1'b1; m_run = 0;
            end
          end else begin
            m_run = 0;
            if (d != 16'h0) m_pred = nxt(d);
          end
        end else begin
          m_wc++;
          old    = m_pred;
          m_pred = nxt(m_pred);
          if (d == old) begin
            m_run = 0;
          end else begin
            cerr = 1'b1;
            m_run++;
            if (m_run == LossN) begin
              m_lk = 1'b0; m_run = 0;
              m_pred = (d != 16'h0) ? nxt(d) : old;
            end
          end
        end
      end
      if (c) m_ec = cerr ? 1 : 0;
      else if (cerr && m_ec < 65535) m_ec++;
    end
    e.lk = m_lk;
    e.ep = cerr;
    e.ec = m_ec[15:0];
    e.ex = m_pred;
    e.wc = WcEn ? m_wc : 32'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("sb_locked", locked, e.lk);
    check_eq("sb_err_pulse", err_pulse, e.ep);
    check_eq("sb_err_cnt", err_cnt, e.ec);
    check_eq("sb_expected", expected, e.ex);
    check_eq("sb_word_cnt", word_cnt, e.wc);
  endtask

  task automatic sdrive(input logic v, input logic [15:0] d, input logic c, input logic r);
    s_valid = v;
    s_q     = d;
    s_clr   = c;
    s_rst   = r;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] g, h;
  int          e_n, run_n;

  initial begin
    valid = 0; q_in = '0; clr_cnt = 0; rst = 1;
    s_valid = 0; s_q = '0; s_clr = 0; s_rst = 1;

    // Reset then lock
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    check_eq("rst_locked", locked, 1'b0);
    check_eq("rst_expected", expected, 16'h0);
    g = 16'hACE1;
    drive(1'b1, g, 1'b0, 1'b0);
    check_eq("seed_expected", expected, 16'h59C3);
    for (int i = 0; i < 4; i++) begin
      g = nxt(g);
      drive(1'b1, g, 1'b0, 1'b0);
      check_eq("lock_progress", locked, (i == 3));
    end
    check_eq("lock_err_cnt", err_cnt, 16'h0);

    // Single error
    g = nxt(g);
    drive(1'b1, g ^ 16'h0001, 1'b0, 1'b0);
    check_eq("single_pulse", err_pulse, 1'b1);
    check_eq("single_err_cnt", err_cnt, 16'd1);
    check_eq("single_locked", locked, 1'b1);
    for (int i = 0; i < 3; i++) begin
      g = nxt(g);
      drive(1'b1, g, 1'b0, 1'b0);
      check_eq("single_no_pulse", err_pulse, 1'b0);
    end

    drive(1'b0, 16'h0, 1'b1, 1'b0);
    check_eq("clr_alone", err_cnt, 16'd0);

    // Loss of lock, then relock
    for (int i = 0; i < 4; i++) begin
      g = nxt(g);
      drive(1'b1, g ^ 16'hFFFF, 1'b0, 1'b0);
      check_eq("loss_pulse", err_pulse, 1'b1);
      check_eq("loss_locked", locked, (i < 3));
    end
    check_eq("loss_err_cnt", err_cnt, 16'd4);
    for (int i = 0; i < 5; i++) begin
      g = nxt(g);
      drive(1'b1, g, 1'b0, 1'b0);
      check_eq("relock", locked, (i == 4));
    end

    drive(1'b0, 16'h1234, 1'b0, 1'b0);
    check_eq("idle_expected", expected, nxt(g));
    check_eq("word_cnt_locked", word_cnt, WcEn ? 32'd8 : 32'd0);

    // Mid-stream reset; the word presented with rst is ignored
    drive(1'b1, nxt(g), 1'b0, 1'b1);
    check_eq("mrst_locked", locked, 1'b0);
    check_eq("mrst_err_pulse", err_pulse, 1'b0);
    check_eq("mrst_err_cnt", err_cnt, 16'h0);
    check_eq("mrst_expected", expected, 16'h0);
    check_eq("mrst_word_cnt", word_cnt, 32'd0);

    // Zero word does not seed; gapped stream still locks after 5 valid words
    drive(1'b1, 16'h0, 1'b0, 1'b0);
    check_eq("zero_noseed", expected, 16'h0);
    g = 16'hACE1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, g, 1'b0, 1'b0);
      check_eq("gap_lock", locked, (i == 4));
      drive(1'b0, 16'hFFFF, 1'b0, 1'b0);
      check_eq("gap_idle_lock", locked, (i == 4));
      check_eq("gap_idle_expected", expected, nxt(g));
      g = nxt(g);
    end

    // Saturation on the LOSS_CNT=15 instance: 14 errors then one good word, repeated
    sdrive(1'b0, 16'h0, 1'b0, 1'b1);
    h = 16'hACE1;
    sdrive(1'b1, h, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      h = nxt(h);
      sdrive(1'b1, h, 1'b0, 1'b0);
    end
    check_eq("sat_locked", s_locked, 1'b1);
    e_n = 0;
    run_n = 0;
    while (e_n < 65535) begin
      h = nxt(h);
      if (run_n < 14) begin
        sdrive(1'b1, h ^ 16'h0001, 1'b0, 1'b0);
        e_n++;
        run_n++;
        if (e_n == 100) check_eq("sat_count100", s_err_cnt, 16'd100);
      end else begin
        sdrive(1'b1, h, 1'b0, 1'b0);
        run_n = 0;
      end
    end
    check_eq("sat_reach", s_err_cnt, 16'hFFFF);
    check_eq("sat_still_locked", s_locked, 1'b1);
    h = nxt(h);
    sdrive(1'b1, h, 1'b0, 1'b0);
    h = nxt(h);
    sdrive(1'b1, h ^ 16'h0001, 1'b0, 1'b0);
    check_eq("sat_hold", s_err_cnt, 16'hFFFF);
    check_eq("sat_pulse", s_err_pulse, 1'b1);
    h = nxt(h);
    sdrive(1'b1, h ^ 16'h0001, 1'b1, 1'b0);
    check_eq("clr_with_err", s_err_cnt, 16'd1);
    sdrive(1'b0, 16'h0, 1'b1, 1'b0);
    check_eq("clr_alone_sat", s_err_cnt, 16'd0);
    check_eq("sat_end_locked", s_locked, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side counterpart of the `lfsr` pattern generator. Accepts a stream of NBITS-wide LFSR words and self-synchronises to it by seeding from received data. Once locked, it predicts each following word and flags, counts and tracks mismatches. It sits at the sink end of a test or replay link, so generator output can be checked in-system rather than only viewed in a waveform.

## Interface
- `NBITS`, 16, word width; must match the generator.
- `TAPS`, 16'hB400, feedback tap mask, NBITS wide; bit i set means state bit i feeds the XOR.
- `LOCK_CNT`, 4, consecutive matches needed to enter LOCKED (1..15).
- `LOSS_CNT`, 4, consecutive mismatches in LOCKED that force re-search (1..15).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid`  in  1  `q_in` carries a word this cycle.
- `q_in`  in  NBITS  received LFSR word.
- `clr_cnt`  in  1  synchronous clear of `err_cnt`.
- `locked`  out  1  checker is in LOCKED.
- `err_pulse`  out  1  one-cycle flag: a mismatch occurred while LOCKED.
- `err_cnt`  out  16  saturating mismatch count while LOCKED.
- `expected`  out  NBITS  predicted value of the next word.
- `word_cnt`  out  32  words checked while LOCKED (see Configuration).

## Operation
- Step function: `fb = ^(s & TAPS)`; `step(s) = {s[NBITS-2:0], fb}`. One step per valid word.
- Register `pred` holds the expected next word. Counter `run` is 4 bits and counts matches in SEARCH and mismatches in LOCKED.
- Cycles with `valid`=0 change no state.
- SEARCH, on valid:
  - If `q_in`==`pred` and `q_in`!=0: `run`++, `pred`<=step(`pred`). When `run` reaches LOCK_CNT, go to LOCKED and set `run`<=0.
  - Otherwise: `run`<=0. `pred`<=step(`q_in`) if `q_in`!=0, else `pred` is unchanged. An all-zero word is the lock-up state and never seeds.
- LOCKED, on valid: `pred`<=step(`pred`) always. The next prediction never reseeds from received data, so isolated bit errors do not desynchronise the checker.
  - Match: `run`<=0.
  - Mismatch: `err_pulse`, `err_cnt`++ (saturates at 16'hFFFF), `run`++. When `run` reaches LOSS_CNT: go to SEARCH, `run`<=0, `pred`<=step(`q_in`) (or unchanged if `q_in`==0).
- `clr_cnt`:
  - With no counted error in the same cycle, sets `err_cnt` to 0.
  - With a counted error in the same cycle, sets `err_cnt` to 1.
- `rst` mid-stream: everything returns to reset values on the next edge. The word presented in the same cycle as `rst` is ignored.

## Timing
- All outputs are registered. Every effect of a valid word at edge N is visible after edge N.
- `locked` rises after the edge that samples the LOCK_CNT-th consecutive match.
- `locked` falls after the edge that samples the LOSS_CNT-th consecutive mismatch. `err_pulse` is also high for that word.
- `err_pulse` is high for exactly one cycle per mismatching word.
- Reset values: `locked`=0, `err_pulse`=0, `err_cnt`=0, `expected`=0, `word_cnt`=0, state SEARCH, `run`=0.
- Back-to-back valid words are supported at one word per clock, with no stall.

## Configuration
- `LFSR_CHK_WORDCNT_EN` defined:
  - `word_cnt` increments on every valid word sampled while LOCKED, matching or not.
  - It wraps at 2^32 and is cleared by `rst` only.
- Not defined: `word_cnt` is a constant 0 and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- Reset then lock: `rst` 1 cycle; feed valid seed 16'hACE1, then 16'h59C3 and its successors. Required: `expected`=16'h59C3 after the first word; `locked`=1 after the 5th word; `err_cnt`=0.
- Single error: while locked, corrupt one word by XOR 16'h0001, then resume the correct sequence. Required: one `err_pulse`; `err_cnt`=1; `locked` stays 1; following words produce no pulse.
- Loss of lock: while locked, feed 4 consecutive wrong words. Required: 4 pulses, `err_cnt`=4, `locked`=0 after the 4th. A correct resumed sequence relocks after 5 more words.
- Zero word and gaps: in SEARCH feed 16'h0000, then the correct sequence with `valid` deasserted every other cycle. Required: zero does not seed; lock is reached after 5 nonzero valid words; idle cycles change nothing.
- Counter edges: with `err_cnt` preloaded to 16'hFFFF by forcing errors, a further error leaves it at 16'hFFFF. `clr_cnt` together with an error gives 1. `clr_cnt` alone gives 0.
- Mid-stream reset and macro: assert `rst` while locked. Required: all outputs 0 next cycle. With `LFSR_CHK_WORDCNT_EN`, `word_cnt` equals the number of valid words sampled while locked; without the macro it stays 0.
